// File: rtl/mem_access_if.sv
// Pipeline-side and memory-side signals of the load/store access unit.
// master = pipeline + memory model side, slave = mem_access.
interface mem_access_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic [31:0] mem_pos;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  busy, done, rdata, misalign, mem_pos, mem_wdata, mem_we
    );

    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output busy, done, rdata, misalign, mem_pos, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access.sv
// MIPS load/store unit over a word-wide memory; sub-word stores read-modify-write (MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned ops).
// Latency: loads/sw done in cycle 1, sh/sb done in cycle 2 after req is seen in IDLE.
// Backpressure: busy stalls the pipeline while an op is in flight; drops in the RESP cycle.
module mem_access (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q;
    logic        done_q;
    logic        misalign_q;
    logic [31:0] rdata_q;
    logic [31:0] word_q;
    logic [31:0] pos_q;
    logic [1:0]  lane_q;
    logic [15:0] sdat_q;
    logic        half_q;

    logic        is_load;
    logic        is_sw;
    logic        is_word;
    logic        is_half;
    logic        mis_d;
    logic        wr_now;
    logic [1:0]  lane_d;
    logic [31:0] lane_word;
    logic [31:0] rdata_d;
    logic [31:0] merge_mask;
    logic [31:0] merge_dat;
    logic [31:0] merged;

    assign is_load = (bus.op <= 3'd4);
    assign is_sw   = (bus.op == 3'd5);
    assign is_word = (bus.op == 3'd0) || (bus.op == 3'd5);
    assign is_half = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd6);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign lane_d = bus.addr[1:0];
    assign mis_d  = (is_word && (bus.addr[1:0] != 2'b00)) || (is_half && bus.addr[0]);
`else
    // Misaligned addresses are silently rounded down to the access size.
    assign lane_d = is_word ? 2'b00 : (is_half ? {bus.addr[1], 1'b0} : bus.addr[1:0]);
    assign mis_d  = 1'b0;
`endif

    assign lane_word = bus.mem_rdata >> {lane_d, 3'b000};

    always_comb begin
        rdata_d = 32'h0;
        case (bus.op)
            3'd0:    rdata_d = bus.mem_rdata;
            3'd1:    rdata_d = {{16{lane_word[15]}}, lane_word[15:0]};
            3'd2:    rdata_d = {16'h0, lane_word[15:0]};
            3'd3:    rdata_d = {{24{lane_word[7]}}, lane_word[7:0]};
            3'd4:    rdata_d = {24'h0, lane_word[7:0]};
            default: rdata_d = 32'h0;
        endcase
    end

    // Replace the latched lane of the word read in IDLE with the store data.
    always_comb begin
        merge_mask = half_q ? (32'h0000_FFFF << {lane_q, 3'b000})
                            : (32'h0000_00FF << {lane_q, 3'b000});
        merge_dat  = {16'h0, sdat_q} << {lane_q, 3'b000};
        merged     = (word_q & ~merge_mask) | (merge_dat & merge_mask);
    end

    assign wr_now = (state_q == IDLE) && bus.req && is_sw && !mis_d;

    assign bus.busy      = ((state_q == IDLE) && bus.req) || (state_q == MERGE);
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.misalign  = misalign_q;
    assign bus.mem_pos   = (state_q == MERGE) ? pos_q : {bus.addr[31:2], 2'b00};
    // Gated by rst_n so a store held on req during reset never reaches memory.
    assign bus.mem_we    = rst_n && (wr_now || (state_q == MERGE));
    assign bus.mem_wdata = !rst_n              ? 32'h0 :
                           (state_q == MERGE)  ? merged :
                           wr_now              ? bus.wdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= 32'h0;
            word_q     <= 32'h0;
            pos_q      <= 32'h0;
            lane_q     <= 2'b00;
            sdat_q     <= 16'h0;
            half_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        if (mis_d) begin
                            misalign_q <= 1'b1;
                            rdata_q    <= 32'h0;
                            done_q     <= 1'b1;
                            state_q    <= RESP;
                        end else if (is_load) begin
                            rdata_q <= rdata_d;
                            done_q  <= 1'b1;
                            state_q <= RESP;
                        end else if (is_sw) begin
                            rdata_q <= 32'h0;
                            done_q  <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            word_q  <= bus.mem_rdata;
                            pos_q   <= {bus.addr[31:2], 2'b00};
                            lane_q  <= lane_d;
                            sdat_q  <= bus.wdata[15:0];
                            half_q  <= is_half;
                            state_q <= MERGE;
                        end
                    end
                end
                MERGE: begin
                    rdata_q <= 32'h0;
                    done_q  <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    rdata_q    <= 32'h0;
                    state_q    <= IDLE;
                end
                default: begin
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    rdata_q    <= 32'h0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store access unit between the pipeline MEM stage and the word-organised data memory (combinational read, write on `clk` rising edge, word index from address bits [11:2]). Accepts one MIPS memory operation at a time (lw/lh/lhu/lb/lbu/sw/sh/sb) and issues word-granular memory accesses. Sub-word stores use a two-cycle read-modify-write. Loads are returned byte- or halfword-extracted and sign- or zero-extended. The unit stalls the pipeline while an access is in flight.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `req`  in  1  MEM stage holds a valid memory op; must stay stable with `op`/`addr`/`wdata` while `busy`=1
- `op`  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
- `addr`  in  32  byte address (ALU result)
- `wdata`  in  32  store data (rt value)
- `busy`  out  1  stall request to pipeline
- `done`  out  1  one-cycle pulse: op complete
- `rdata`  out  32  extended load result; valid while `done`=1, 0 for stores
- `misalign`  out  1  misaligned-access flag, valid with `done`
- `mem_pos`  out  32  memory address, low two bits always 0
- `mem_wdata`  out  32  memory write word
- `mem_we`  out  1  memory write enable
- `mem_rdata`  in  32  memory read word (combinational from `mem_pos`)

## Operation
- Little-endian byte lanes: byte k = bits [8k+7:8k], where k = addr[1:0]. Halfword h = addr[1], bits [16h+15:16h].
- FSM states: IDLE, MERGE, RESP.
- IDLE:
  - `mem_pos` = {addr[31:2],2'b00}.
  - Load with `req`: capture the extracted/extended `mem_rdata` into `rdata`, go to RESP.
  - sw with `req`: `mem_we`=1 this cycle, `mem_wdata`=`wdata`, go to RESP.
  - sh/sb with `req`: latch `mem_rdata` word, word address, lane and store data, go to MERGE.
- MERGE:
  - `mem_pos` = latched word address; `mem_we`=1.
  - `mem_wdata` = latched word with the target lane replaced by `wdata[15:0]` (sh) or `wdata[7:0]` (sb).
  - Go to RESP.
- RESP: `done`=1, go to IDLE; `req` is ignored in this state.
- `busy` = (IDLE & `req`) | MERGE. Combinational; low in RESP, so the pipeline advances in the RESP cycle.
- Extension: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend. Store ops leave `rdata`=0.
- `mem_we`/`mem_wdata` are 0 outside the write cycles listed above.

## Timing
- Reset values:
  - state IDLE; `done`, `rdata`, `misalign` = 0.
  - Merge buffers 0.
  - `mem_we`=0, `mem_wdata`=0.
  - `busy` = `req` (combinational).
- Latency, counted from the cycle `req` is first high in IDLE (cycle 0):
  - Loads and sw: 1 busy cycle, `done` in cycle 1.
  - sh/sb: 2 busy cycles (read in cycle 0, write in cycle 1), `done` in cycle 2.
- Back-to-back ops: the next `req` is accepted at the earliest in the cycle after RESP.
- Reset asserted during MERGE: the write is aborted, no `mem_we` pulse, state returns to IDLE.
- Address wrap: only addr[11:2] selects the memory word. Upper bits pass through on `mem_pos` unchanged.

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined:
  - Misaligned means lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]≠0.
  - A misaligned op takes IDLE→RESP directly: `misalign`=1 with `done`, no `mem_we`, `rdata`=0.
- Undefined:
  - `misalign` tied 0.
  - Misaligned addresses are force-aligned (addr[1:0] cleared for word ops, addr[0] cleared for halfword ops).
  - The op then executes normally.

## Test plan
- Reset: `rst_n` low in the MERGE cycle of sb 0x1 → no `mem_we`; `done`=0, `rdata`=0 after release; FSM idle.
- lw 0x8, word 0x11223344 → `busy` 1 cycle, `done` cycle 1, `rdata`=0x11223344, `mem_pos`=0x8.
- lb vs lbu on 0xB, word 0x80FF7F01 → lb `rdata`=0xFFFFFF80; lbu `rdata`=0x00000080. lh 0xA → 0xFFFF80FF.
- sh 0x6, `wdata`=0xAAAA5678, word at 0x4 = 0x11223344 → 2 busy cycles; `mem_we` in cycle 1 with `mem_wdata`=0x56783344; `done` cycle 2.
- sb 0x1 `wdata`=0xEF over 0x00000000, then lw 0x0 → write 0x0000EF00, lw returns 0x0000EF00.
- lw 0x2 → with macro: `misalign`=1, `rdata`=0, no write. Without macro: reads word 0x0, `misalign`=0.
